muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer that owns the architectural HI/LO register pair.
- Replaces the single-edge mult/div path with an iterative radix-2 datapath: shift-add multiply and restoring divide, with a start/busy/done handshake.
- Sits beside the combinational ALU. The control unit launches ops and stalls on busy for mfhi/mflo; mthi/mtlo write HI/LO directly.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  launch request; sampled only in IDLE.
op  input  2  00 multu, 01 divu, 10 mult (signed), 11 div (signed).
a  input  WIDTH  multiplicand / dividend.
b  input  WIDTH  multiplier / divisor.
wr_hi  input  1  mthi write strobe.
wr_lo  input  1  mtlo write strobe.
wdata  input  WIDTH  data for mthi/mtlo.
ready  output  1  high in IDLE.
busy  output  1  high in CALC, FIX and DONE.
done  output  1  one-cycle pulse; HI/LO hold the new result in that cycle.
div_by_zero  output  1  valid only while done=1; high if a div op had b=0.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; hi, lo, working registers and counter cleared to 0.
  - ready=1, busy=0, done=0, div_by_zero=0.
  - Applies immediately, including mid-operation; the aborted op is discarded with no partial commit.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at edge E0 latches a, b and op into working registers, clears counter → CALC.
  - start=0 → stay in IDLE.
- CALC: one iteration per edge; counter increments.
  - Multiply: if multiplier LSB is set, add multiplicand to the upper accumulator half (WIDTH+1-bit add keeps the carry), then shift the 2*WIDTH accumulator right by 1.
  - Divide: shift {rem, quo} left by 1; trial-subtract b from rem; if non-negative, keep the difference and set quo LSB.
  - After WIDTH iterations → FIX if signed and sign correction is needed, else → DONE.
- FIX (one cycle): apply the sign correction (see Optional Feature) → DONE.
- DONE:
  - On the entry edge, hi/lo are loaded: mult → hi=product[2W-1:W], lo=product[W-1:0]; div → lo=quotient, hi=remainder.
  - done=1 for exactly this cycle, then → IDLE.
- Latency, start sampled at E0:
  - Unsigned: done in the cycle after edge E0+WIDTH+1, i.e. 33 cycles for WIDTH=32.
  - Signed with correction: +1 cycle.
- HI/LO are architectural:
  - Unchanged during CALC/FIX; only the DONE entry edge or wr_hi/wr_lo modifies them.
  - mfhi/mflo readers stall while busy=1.
- start while busy: ignored; no queueing, no effect on the running op.
- wr_hi/wr_lo:
  - In IDLE: write on the edge. If start is also high that edge, the write occurs and the op launches; the op result later overwrites both.
  - While busy: writes ignored.
- Divide by zero (b=0): lo = all ones, hi = dividend a (original value), div_by_zero=1 with done. Takes normal latency.
- Signed overflow (MIN / -1): lo=MIN, hi=0, div_by_zero=0.
- No overflow flag for multiply; the full 2*WIDTH product is always exact.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - op[1]=1 selects signed ops. Operands are converted to magnitude at latch; result signs are recorded.
  - FIX negates as required:
    - product: sign = a^b;
    - quotient: sign = a^b, truncated toward zero;
    - remainder: sign follows the dividend.
  - FIX is entered only when at least one negation is required.
- Undefined:
  - op[1] is ignored; all ops are unsigned.
  - The FIX state and its negation logic are not built; latency is always WIDTH+1.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF → done at cycle 33 after start; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1-33.
- divu a=100 b=7 → lo=14, hi=2, div_by_zero=0; divu a=5 b=0 → lo=0xFFFFFFFF, hi=5, div_by_zero=1.
- Preload wr_hi=0x1234, wr_lo=0x5678; start multu 3*4; pulse start again and wr_hi=0xDEAD at cycle 10 → both ignored; hi/lo stay 0x1234/0x5678 until done; then hi=0, lo=12; exactly one done pulse.
- reset_n low at cycle 10 of a divu → ready=1, busy=0, hi=lo=0 immediately. New divu 9/3 after release → lo=3, hi=0.
- MULDIV_SIGNED_EN defined:
  - mult -3*7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB, done at cycle 34.
  - div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div 0x80000000 / -1 → lo=0x80000000, hi=0.
- MULDIV_SIGNED_EN undefined: op=10 with a=0xFFFFFFFD, b=7 → treated as multu: hi=0x00000006, lo=0xFFFFFFEB, done at cycle 33.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply/divide owning the HI/LO pair.
// Signed mult/div and the FIX state are built only with MULDIV_SIGNED_EN.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0]   opnd, a_orig;
  logic               is_div, dbz;
  logic               last, fix_req;
  logic [WIDTH:0]     sum, trial_rem;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULDIV_SIGNED_EN
  logic sgn_op, bz_div, neg_lo, neg_hi;

  assign sgn_op  = op[1];
  assign bz_div  = op[0] && (b == '0);
  assign a_mag   = (sgn_op && a[WIDTH-1]) ? -a : a;
  assign b_mag   = (sgn_op && b[WIDTH-1]) ? -b : b;
  assign fix_req = neg_lo | neg_hi;

  // Result signs; divide-by-zero keeps the raw dividend, so no fix there
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_lo <= sgn_op && !bz_div && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi <= sgn_op && !bz_div &&
                (op[0] ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]));
    end
  end
`else
  logic unused_op;

  assign unused_op = op[1];
  assign a_mag     = a;
  assign b_mag     = b;
  assign fix_req   = 1'b0;
`endif

  assign last        = (cnt == CNT_W'(WIDTH));
  assign ready       = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign div_by_zero = done && dbz;

  // One radix-2 step: shift-add multiply or restoring divide
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
        + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    trial_rem = acc[2*WIDTH-1:WIDTH-1];
    ge        = (trial_rem >= {1'b0, opnd});
    diff      = trial_rem[WIDTH-1:0] - opnd;
    if (is_div) begin
      acc_nx = ge ? {diff, acc[WIDTH-2:0], 1'b1}
                  : {trial_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nx = {sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    res_hi = acc[2*WIDTH-1:WIDTH];
    res_lo = acc[WIDTH-1:0];
    if (dbz) begin
      res_hi = a_orig;
      res_lo = '1;
    end
`ifdef MULDIV_SIGNED_EN
    if (state == FIX) begin
      if (!is_div) begin
        {res_hi, res_lo} = -acc;
      end else begin
        if (neg_hi) res_hi = -acc[2*WIDTH-1:WIDTH];
        if (neg_lo) res_lo = -acc[WIDTH-1:0];
      end
    end
`endif
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last) state_nx = fix_req ? FIX : DONE;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_orig <= '0;
      is_div <= 1'b0;
      dbz    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start) begin
            acc    <= {{WIDTH{1'b0}}, (op[0] ? a_mag : b_mag)};
            opnd   <= op[0] ? b_mag : a_mag;
            a_orig <= a;
            is_div <= op[0];
            dbz    <= op[0] && (b == '0);
            cnt    <= '0;
          end
        end
        CALC: begin
          if (!last) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
          end else if (!fix_req) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        FIX: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors with a queue scoreboard and a done monitor.
// Signed vectors are compiled when MULDIV_SIGNED_EN is defined.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        wr_hi, wr_lo;
  logic [31:0] wdata;
  logic        ready, busy, done, div_by_zero;
  logic [31:0] hi, lo;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .a(a), .b(b), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .ready(ready), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected none at cyc %0d",
                 cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("hi", 64'(hi), 64'(mon_e.hi));
        chk("lo", 64'(lo), 64'(mon_e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
        if (mon_e.cyc >= 0) chk("latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edbz,
                        input int lat, input bit push, input bit wl,
                        input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    wr_lo = wl;
    wdata = wd;
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.dbz = edbz;
      e.cyc = (lat < 0) ? -1 : cyc + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    wr_lo = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] ehi,
                     input logic [31:0] elo, input logic edbz,
                     input int lat);
    launch(o, av, bv, ehi, elo, edbz, lat, 1'b1, 1'b0, 32'h0);
    wait_done();
  endtask

  initial begin
    int bad;
    int d0;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    a       = '0;
    b       = '0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    wdata   = '0;
    repeat (2) @(negedge clk);
    chk("reset_flags", 64'({ready, busy, done, div_by_zero}), 64'(4'b1000));
    chk("reset_hilo", {hi, lo}, 64'h0);
    reset_n = 1'b1;

    // multu max*max, busy over the whole calculation
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,
           1'b0, 33, 1'b1, 1'b0, 32'h0);
    bad = 0;
    for (int i = 0; i < 33; i++) begin
      if (!busy || ready) bad++;
      @(negedge clk);
    end
    chk("busy_window", 64'(bad), 64'h0);
    wait_done();

    run(2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    run(2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 33);
    run(2'b01, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0, 33);
    run(2'b01, 32'd7, 32'd9, 32'd7, 32'd0, 1'b0, 33);
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 33);
    run(2'b00, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0, 33);

    // mthi/mtlo preload, then start and mthi during busy are ignored
    @(negedge clk);
    wr_hi = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    wr_hi = 1'b0;
    wr_lo = 1'b1;
    wdata = 32'h5678;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("preload", {hi, lo}, {32'h1234, 32'h5678});
    d0 = done_cnt;
    launch(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33,
           1'b1, 1'b0, 32'h0);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd100;
    b     = 32'd7;
    wr_hi = 1'b1;
    wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    wr_hi = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (hi !== 32'h1234 || lo !== 32'h5678 || !busy) bad++;
      @(negedge clk);
    end
    chk("hilo_hold", 64'(bad), 64'h0);
    wait_done();
    repeat (40) @(negedge clk);
    chk("one_done", 64'(done_cnt - d0), 64'h1);

    // mtlo together with start: write lands, result later overwrites
    launch(2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33,
           1'b1, 1'b1, 32'hAAAA);
    chk("wr_with_start", 64'(lo), 64'hAAAA);
    wait_done();

    // async reset in the middle of a divide
    launch(2'b01, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b0, 33,
           1'b0, 1'b0, 32'h0);
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_flags", 64'({ready, busy, done}), 64'(3'b100));
    chk("abort_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run(2'b01, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 33);

`ifdef MULDIV_SIGNED_EN
    run(2'b10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
    run(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, -1);
    run(2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34);
    run(2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 33);
    run(2'b10, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33);
`else
    run(2'b10, 32'hFFFF_FFFD, 32'd7, 32'h6, 32'hFFFF_FFEB, 1'b0, 33);
    run(2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0, 33);
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
